// File: rtl/reg_file_scb.sv
// Register file with write-to-read bypass, per-register busy scoreboard and a
// post-reset clear sequencer that zeroes the array instead of a wide reset.
module reg_file_scb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned AW     = 5,
  parameter bit          BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ready,
  input  logic            we,
  input  logic [AW-1:0]   wi,
  input  logic [XLEN-1:0] wd,
  input  logic [AW-1:0]   rs1i,
  output logic [XLEN-1:0] rs1,
  input  logic [AW-1:0]   rs2i,
  output logic [XLEN-1:0] rs2,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_idx,
  input  logic            flush,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            wb_err
);

  localparam int unsigned NREG = 2**AW;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t            state, state_d;
  logic [AW-1:0]     cnt, cnt_d;
  logic [NREG-1:0]   busy, busy_d;
  logic [XLEN-1:0]   mem [NREG];
  logic              mem_we;
  logic [AW-1:0]     mem_idx;
  logic [XLEN-1:0]   mem_wd;
  logic              run;
  logic              err_d;

  assign run   = (state == S_RUN);
  assign ready = run;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_CLEAR;
      cnt    <= AW'(1);
      busy   <= '0;
      wb_err <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      busy   <= busy_d;
      wb_err <= err_d;
    end
  end

  // The clear sequencer and the writeback port share the single array write port.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    mem_we  = 1'b0;
    mem_idx = wi;
    mem_wd  = wd;
    unique case (state)
      S_CLEAR: begin
        mem_we  = 1'b1;
        mem_idx = cnt;
        mem_wd  = '0;
        cnt_d   = cnt + AW'(1);
        if (cnt == AW'(NREG - 1)) state_d = S_RUN;
      end
      S_RUN: begin
        if (we && (wi != '0)) mem_we = 1'b1;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= mem_wd;
  end

  // Issue is applied after writeback so a new producer keeps the register pending.
  always_comb begin
    busy_d = busy;
    if (run) begin
      if (flush) begin
        busy_d = '0;
      end else begin
        if (we) busy_d[wi] = 1'b0;
        if (iss_en) busy_d[iss_idx] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  assign err_d = run && we && (wi != '0) && !busy[wi] && !flush;

  always_comb begin
    rs1      = '0;
    rs1_busy = 1'b0;
    if (run && (rs1i != '0)) begin
      if (BYPASS && we && (wi == rs1i)) begin
        rs1 = wd;
      end else begin
        rs1      = mem[rs1i];
        rs1_busy = busy[rs1i];
      end
    end
  end

  always_comb begin
    rs2      = '0;
    rs2_busy = 1'b0;
    if (run && (rs2i != '0)) begin
      if (BYPASS && we && (wi == rs2i)) begin
        rs2 = wd;
      end else begin
        rs2      = mem[rs2i];
        rs2_busy = busy[rs2i];
      end
    end
  end

endmodule

// File: tb/tb_reg_file_scb.sv
// Bench for reg_file_scb: one bypassing and one non-bypassing instance on shared
// stimulus, checked every cycle against a behavioural register/scoreboard model.
module tb_reg_file_scb;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            we;
  logic [AW-1:0]   wi;
  logic [XLEN-1:0] wd;
  logic [AW-1:0]   rs1i, rs2i;
  logic            iss_en;
  logic [AW-1:0]   iss_idx;
  logic            flush;

  logic            ready_b, ready_n;
  logic [XLEN-1:0] rs1_b, rs2_b, rs1_n, rs2_n;
  logic            rs1_busy_b, rs2_busy_b, rs1_busy_n, rs2_busy_n;
  logic            wb_err_b, wb_err_n;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  reg_file_scb #(.XLEN(XLEN), .AW(AW), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .ready(ready_b), .we(we), .wi(wi), .wd(wd),
    .rs1i(rs1i), .rs1(rs1_b), .rs2i(rs2i), .rs2(rs2_b),
    .iss_en(iss_en), .iss_idx(iss_idx), .flush(flush),
    .rs1_busy(rs1_busy_b), .rs2_busy(rs2_busy_b), .wb_err(wb_err_b)
  );

  reg_file_scb #(.XLEN(XLEN), .AW(AW), .BYPASS(1'b0)) dut0 (
    .clk(clk), .rst(rst), .ready(ready_n), .we(we), .wi(wi), .wd(wd),
    .rs1i(rs1i), .rs1(rs1_n), .rs2i(rs2i), .rs2(rs2_n),
    .iss_en(iss_en), .iss_idx(iss_idx), .flush(flush),
    .rs1_busy(rs1_busy_n), .rs2_busy(rs2_busy_n), .wb_err(wb_err_n)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: contents are all zero the moment the clear completes; until then the
  // register file is "not ready" and reads nothing.
  bit              m_run;
  int              m_clear_cycles;
  logic [XLEN-1:0] m_reg [NREG];
  bit   [NREG-1:0] m_busy;
  bit              m_err;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run = 0;
      m_clear_cycles = 0;
      m_busy = '0;
      m_err = 0;
    end else if (!m_run) begin
      m_clear_cycles++;
      m_err = 0;
      if (m_clear_cycles == NREG - 1) begin
        m_run = 1;
        foreach (m_reg[i]) m_reg[i] = '0;
      end
    end else begin
      m_err = we && (wi != 0) && !m_busy[wi] && !flush;
      if (we && (wi != 0)) m_reg[wi] = wd;
      if (flush) m_busy = '0;
      else begin
        if (we) m_busy[wi] = 0;
        if (iss_en && (iss_idx != 0)) m_busy[iss_idx] = 1;
      end
    end
  end

  function automatic logic [31:0] exp_rd(input bit byp, input logic [AW-1:0] ri);
    if (!m_run || ri == 0) return '0;
    if (byp && we && wi == ri) return wd;
    return m_reg[ri];
  endfunction

  function automatic logic [31:0] exp_busy(input bit byp, input logic [AW-1:0] ri);
    if (!m_run || ri == 0) return '0;
    if (byp && we && wi == ri) return '0;
    return 32'(m_busy[ri]);
  endfunction

  always @(negedge clk) begin
    check("ready.byp",    32'(ready_b),    32'(m_run));
    check("rs1.byp",      rs1_b,           exp_rd(1, rs1i));
    check("rs2.byp",      rs2_b,           exp_rd(1, rs2i));
    check("rs1_busy.byp", 32'(rs1_busy_b), exp_busy(1, rs1i));
    check("rs2_busy.byp", 32'(rs2_busy_b), exp_busy(1, rs2i));
    check("wb_err.byp",   32'(wb_err_b),   32'(m_err));
    check("ready.nob",    32'(ready_n),    32'(m_run));
    check("rs1.nob",      rs1_n,           exp_rd(0, rs1i));
    check("rs2.nob",      rs2_n,           exp_rd(0, rs2i));
    check("rs1_busy.nob", 32'(rs1_busy_n), exp_busy(0, rs1i));
    check("rs2_busy.nob", 32'(rs2_busy_n), exp_busy(0, rs2i));
    check("wb_err.nob",   32'(wb_err_n),   32'(m_err));
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; iss_en = 0; flush = 0;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (n < 100) begin
      next_cycle();
      n++;
      if (ready_b) break;
    end
    check(name, 32'(n), 32'(NREG - 1));
  endtask

  initial begin
    rst = 0; we = 0; wi = 0; wd = 0; rs1i = 0; rs2i = 0;
    iss_en = 0; iss_idx = 0; flush = 0;
    next_cycle();
    next_cycle();
    check("reset.ready", 32'(ready_b), 32'd0);
    check("reset.wb_err", 32'(wb_err_b), 32'd0);

    // Release with a write attempt pending throughout CLEAR
    we = 1; wi = 3; wd = 32'hDEADBEEF; rs1i = 3; rs2i = 31;
    rst = 1;
    wait_ready("clear_latency");
    idle();

    for (int i = 1; i < NREG; i++) begin
      rs1i = AW'(i); rs2i = AW'(NREG - i);
      #3;
      check("clear.rs1", rs1_b, 32'd0);
      check("clear.rs2", rs2_n, 32'd0);
      next_cycle();
    end

    // Same-cycle write/read on index 5
    we = 1; wi = 5; wd = 32'h12345678; rs1i = 5; rs2i = 0;
    #3;
    check("wr5.byp_same", rs1_b, 32'h12345678);
    check("wr5.nob_same", rs1_n, 32'd0);
    next_cycle();
    we = 0;
    #3;
    check("wr5.nob_next", rs1_n, 32'h12345678);
    next_cycle();
    we = 1; wi = 0; wd = 32'hFFFFFFFF; rs2i = 0;
    #3;
    check("wr0.rs2", rs2_b, 32'd0);
    next_cycle();
    idle();

    // Busy set by issue, cleared by writeback
    iss_en = 1; iss_idx = 7; rs1i = 7;
    #3;
    check("iss7.not_yet", 32'(rs1_busy_b), 32'd0);
    next_cycle();
    iss_en = 0;
    #3;
    check("iss7.busy", 32'(rs1_busy_b), 32'd1);
    next_cycle();
    we = 1; wi = 7; wd = 32'h000000A5;
    #3;
    check("wb7.byp_fwd", 32'(rs1_busy_b), 32'd0);
    check("wb7.nob_busy", 32'(rs1_busy_n), 32'd1);
    next_cycle();
    we = 0;
    #3;
    check("wb7.cleared", 32'(rs1_busy_n), 32'd0);
    check("wb7.no_err", 32'(wb_err_b), 32'd0);
    next_cycle();

    // Issue and writeback collide on 9: set wins
    iss_en = 1; iss_idx = 9;
    next_cycle();
    we = 1; wi = 9; wd = 32'h99; iss_en = 1; iss_idx = 9;
    next_cycle();
    idle(); rs2i = 9;
    #3;
    check("coll9.busy", 32'(rs2_busy_b), 32'd1);
    check("coll9.no_err", 32'(wb_err_n), 32'd0);
    next_cycle();

    // Writeback to non-busy 12 -> single-cycle error pulse
    we = 1; wi = 12; wd = 32'hC;
    #3;
    check("wb12.err_not_yet", 32'(wb_err_b), 32'd0);
    next_cycle();
    we = 0;
    #3;
    check("wb12.err", 32'(wb_err_b), 32'd1);
    next_cycle();
    #3;
    check("wb12.err_gone", 32'(wb_err_b), 32'd0);
    next_cycle();

    // Flush beats a same-cycle issue
    iss_en = 1; iss_idx = 3;
    next_cycle();
    iss_idx = 7;
    next_cycle();
    iss_en = 0; rs1i = 3; rs2i = 7;
    #3;
    check("pre_flush.b3", 32'(rs1_busy_b), 32'd1);
    check("pre_flush.b7", 32'(rs2_busy_b), 32'd1);
    next_cycle();
    flush = 1; iss_en = 1; iss_idx = 4; we = 1; wi = 20; wd = 32'h20;
    next_cycle();
    idle(); rs1i = 4; rs2i = 9;
    #3;
    check("flush.b4", 32'(rs1_busy_b), 32'd0);
    check("flush.b9", 32'(rs2_busy_b), 32'd0);
    check("flush.no_err", 32'(wb_err_b), 32'd0);
    next_cycle();

    // Write a distinct pattern everywhere, read back one cycle later
    for (int i = 1; i < NREG; i++) begin
      we = 1; wi = AW'(i); wd = 32'h01010101 * 32'(i); rs1i = AW'(i); rs2i = AW'(i - 1);
      next_cycle();
    end
    we = 0;
    for (int i = 1; i < NREG; i++) begin
      rs1i = AW'(i); rs2i = AW'(NREG - i);
      #3;
      check("pattern.rs1", rs1_n, 32'h01010101 * 32'(i));
      next_cycle();
    end

    // Async reset mid-run with 5, 7 non-zero and 7 pending
    iss_en = 1; iss_idx = 7;
    next_cycle();
    iss_en = 0; rs1i = 5; rs2i = 7;
    #2;
    check("pre_rst.rs1", rs1_b, 32'h05050505);
    check("pre_rst.b7", 32'(rs2_busy_b), 32'd1);
    rst = 0;
    #1;
    check("rst.ready", 32'(ready_b), 32'd0);
    check("rst.rs1", rs1_b, 32'd0);
    check("rst.rs2", rs2_n, 32'd0);
    check("rst.b7", 32'(rs2_busy_b), 32'd0);
    next_cycle();
    next_cycle();
    rst = 1;
    wait_ready("reclear_latency");
    #3;
    check("reclear.rs1", rs1_b, 32'd0);
    check("reclear.rs2", rs2_n, 32'd0);
    check("reclear.b7", 32'(rs2_busy_b), 32'd0);
    next_cycle();
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_file_scb.md
Name: reg_file_scb

Overview:
- Parametrised successor of the core register file: one write port, two asynchronous read ports, hardwired-zero register 0.
- Adds an optional write-to-read bypass and a per-register busy scoreboard (issue sets, writeback clears).
- Adds a post-reset clear sequencer that zeroes the array, so contents are defined without a wide reset.
- Sits between DECO_INSTR (indexes) and the execute/writeback path of mriscvcore.

Parameters:
- XLEN, 32, data width of each register.
- AW, 5, index width; NREG = 2**AW registers.
- BYPASS, 1, 1 = same-cycle writeback data/busy forwarded to read ports; 0 = read returns array contents only.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- ready  out  1  high once clear sequence is complete.
- we  in  1  writeback enable.
- wi  in  AW  writeback index.
- wd  in  XLEN  writeback data.
- rs1i  in  AW  read index A.
- rs1  out  XLEN  read data A.
- rs2i  in  AW  read index B.
- rs2  out  XLEN  read data B.
- iss_en  in  1  issue strobe: destination iss_idx becomes pending.
- iss_idx  in  AW  destination index of the issued instruction.
- flush  in  1  clear all busy bits (pipeline flush).
- rs1_busy  out  1  register rs1i has a pending write.
- rs2_busy  out  1  register rs2i has a pending write.
- wb_err  out  1  registered pulse: writeback to a non-busy register.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst=0), asynchronous: state=CLEAR, clear counter=1, busy[]=0, ready=0, wb_err=0.
- Outputs during reset and CLEAR: rs1=rs2=0, rs1_busy=rs2_busy=0.
- Reset asserted mid-operation restarts CLEAR; array contents are then overwritten by the sequence.
- FSM CLEAR:
  - Each cycle writes 0 to reg[cnt], then cnt++.
  - After writing index NREG-1, go to RUN; ready=1 from the next cycle.
  - This takes NREG-1 cycles after rst deasserts.
  - we, iss_en and flush are ignored in CLEAR; wb_err stays 0.
- FSM RUN:
  - Stays in RUN until reset; there is no other exit.
- Write (RUN):
  - If we && wi!=0, reg[wi] <= wd at the edge.
  - A write to index 0 is discarded.
- Read (RUN, combinational), for each port with index ri:
  - ri==0 -> output 0.
  - Else if BYPASS && we && wi==ri -> output wd.
  - Else -> output reg[ri].
- Scoreboard (RUN), per index i!=0, next-state priority:
  1. flush -> busy[i]=0 for all i.
  2. iss_en && iss_idx==i -> busy[i]=1. Set beats a same-cycle clear (new producer issued while the old one writes back).
  3. we && wi==i -> busy[i]=0.
  - busy[0] is constantly 0; iss_idx==0 has no effect.
- Busy outputs:
  - rsX_busy = busy[rsXi], except 0 when BYPASS && we && wi==rsXi (data is forwarded this cycle).
- wb_err:
  - Registered, one cycle after we && wi!=0 && !busy[wi] && state==RUN.
  - Pulse width one cycle.
  - Not raised on flush cycles.
- Write and read to the same index with BYPASS=0: read returns the old value; the new value is visible next cycle.
- Latency: write to read-visible = 0 cycles (BYPASS=1) or 1 cycle (BYPASS=0). Issue to busy-visible = 1 cycle.

Test Plan:
- Reset release, count cycles: ready rises exactly NREG-1=31 cycles after rst goes high; all 31 registers read 0; rs1/rs2 stay 0 during CLEAR even if we=1, wi=3, wd=0xDEADBEEF.
- RUN, write wi=5, wd=0x12345678, read rs1i=5 same cycle: BYPASS=1 -> rs1=0x12345678 that cycle; BYPASS=0 -> old value 0, then 0x12345678 next cycle; write wi=0, wd=0xFFFFFFFF -> rs2i=0 reads 0.
- Busy set/clear: iss_en, iss_idx=7 -> rs1_busy (rs1i=7) =1 next cycle; we, wi=7 -> rs1_busy=0 that cycle (BYPASS=1); busy[7]=0 after the edge; wb_err stays 0.
- Simultaneous issue and writeback on index 9 (busy[9]=1): after the edge busy[9]=1 (set wins); wb_err=0.
- Writeback wi=12 with busy[12]=0 -> wb_err=1 for exactly one cycle, one cycle later; flush with busy[3,7]=1 and iss_en iss_idx=4 same cycle -> all busy bits 0.
- Async reset asserted mid-RUN with registers 5 and 7 non-zero and busy[7]=1: ready=0, busy cleared, rs outputs 0 immediately; after re-release, registers 5 and 7 read 0 when ready=1.
